// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub ops, iterative shift-add multiply and
// restoring divide over WIDTH clocks, registered results with a one-cycle done pulse.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ins,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err,
    output logic             busy,
    output logic             done,
    output logic             dbg_state
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             op_div;

    // Handshake: an op is accepted on any rising edge where start=1 and busy=0;
    // done is high for exactly the one cycle following the edge that completes it.
    logic launch_multi;
    assign launch_multi = start && ((ins == 4'd9) || ((ins == 4'd10) && (B != '0)));

    // Single-cycle result path
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] s_out;
    logic [WIDTH-1:0] s_hi;
    logic             s_zero;
    logic             s_carry;
    logic             s_ovf;
    logic             s_err;

    always_comb begin
        sum_add = {1'b0, A} + {1'b0, B};
        sum_sub = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        s_out   = '0;
        s_hi    = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_err   = 1'b0;
        case (ins)
            4'd0: begin
                s_out   = sum_add[MSB:0];
                s_carry = sum_add[WIDTH];
                s_ovf   = (A[MSB] == B[MSB]) && (sum_add[MSB] != A[MSB]);
            end
            4'd1: begin
                s_out   = sum_sub[MSB:0];
                s_carry = sum_sub[WIDTH];
                s_ovf   = (A[MSB] == ~B[MSB]) && (sum_sub[MSB] != A[MSB]);
            end
            4'd2: s_out = A & B;
            4'd3: s_out = A | B;
            4'd4: s_out = A ^ B;
            4'd5: s_out = ~A;
            4'd6: s_out = A << B[SHW-1:0];
            4'd7: s_out = A >> B[SHW-1:0];
            4'd8: s_out = WIDTH'($signed(A) < $signed(B));
            4'd9: s_out = '0;
            4'd10: begin
                // Only the divide-by-zero case completes on this path.
                s_out = '1;
                s_hi  = A;
                s_err = 1'b1;
            end
            default: s_err = 1'b1;
        endcase
        s_zero = (s_out == '0);
    end

    // One multiply / divide iteration
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] lo_nx;

    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, lo[MSB]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        acc_nx    = mul_sum[WIDTH:1];
        lo_nx     = {mul_sum[0], lo[MSB:1]};
        if (op_div) begin
            acc_nx = div_ge ? div_diff[MSB:0] : div_shift[MSB:0];
            lo_nx  = {lo[MSB-1:0], div_ge};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch_multi) state_nx = RUN;
            RUN:     if (cnt == CW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out    <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            lo     <= '0;
            opnd   <= '0;
            op_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_multi) begin
                        acc    <= '0;
                        lo     <= A;
                        opnd   <= B;
                        op_div <= (ins == 4'd10);
                        cnt    <= CW'(WIDTH);
                    end else if (start) begin
                        out   <= s_out;
                        hi    <= s_hi;
                        zero  <= s_zero;
                        carry <= s_carry;
                        ovf   <= s_ovf;
                        err   <= s_err;
                        done  <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    lo  <= lo_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out   <= lo_nx;
                        hi    <= acc_nx;
                        carry <= 1'b0;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        if (op_div) begin
                            zero <= (lo_nx == '0);
                            ovf  <= 1'b0;
                        end else begin
                            zero <= (lo_nx == '0) && (acc_nx == '0);
                            ovf  <= (acc_nx != '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign dbg_state = state;

endmodule
